budget_watchdog_timer: RTL

// - Consumer end of the dynamic budget path: takes the accumulated cycle budget of outstanding txns and enforces it.
// - Per-monitor (AW/W or AR/R) countdown, ticked by a prescaler.
// - Reloads on forward progress; flags a timeout when the budget expires with txns still outstanding.
// - Sits between the budget adder and the monitor's IRQ / error-response logic.

---
 rtl/budget_watchdog_timer_pkg.sv | 22 ++
 rtl/budget_watchdog_timer_prescaler.sv | 33 +++
 rtl/budget_watchdog_timer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/budget_watchdog_timer_pkg.sv
// Shared types and constants for the budget monitor path (budget adder and
// watchdog timer).
package budget_watchdog_timer_pkg;

    localparam int unsigned MAX_TXNS      = 8;
    localparam int unsigned PRESCALER_DIV = 2;
    localparam int unsigned CNT_WIDTH     = 16;
    localparam int unsigned OUT_WIDTH     = $clog2(MAX_TXNS + 1);

    // Cycles of fixed overhead charged per transaction by the budget adder.
    localparam int unsigned TXN_OVERHEAD  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        TIMEOUT = 2'd2
    } state_e;

    typedef logic [CNT_WIDTH-1:0] budget_cnt_t;
    typedef logic [OUT_WIDTH-1:0] outstanding_t;

endpackage

// File: rtl/budget_watchdog_timer_prescaler.sv
// Free-running mod-Div counter; tick_o marks the wrap cycle.
// Div=1 ticks every cycle.
module budget_prescaler #(
    parameter int unsigned Div = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned PW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [PW-1:0] LAST = PW'(Div - 1);

    logic [PW-1:0] cnt_q;

    // Count up and wrap at LAST; a clear restarts the budget unit.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Tick on the final count of each budget unit.
    always_comb begin
        tick_o = (cnt_q == LAST);
    end

endmodule

// File: rtl/budget_watchdog_timer.sv
// Watchdog that enforces the accumulated cycle budget of outstanding txns:
// counts down per prescaler tick, reloads on progress, and latches a timeout.
module budget_watchdog_timer
    import budget_watchdog_timer_pkg::*;
#(
    parameter int unsigned MaxTxns      = MAX_TXNS,
    parameter int unsigned PrescalerDiv = PRESCALER_DIV,
    parameter int unsigned CntWidth     = CNT_WIDTH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [CntWidth-1:0]              budget_i,
    input  logic [$clog2(MaxTxns+1)-1:0]     outstanding_i,
    input  logic                             progress_i,
    input  logic                             enable_i,
    input  logic                             clear_i,
    output logic                             timeout_o,
    output logic                             irq_o,
    output logic [CntWidth-1:0]              remaining_o
);

    localparam logic [CntWidth-1:0] ONE = CntWidth'(1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] counter_q, counter_d;
    logic [CntWidth-1:0] budget_q;
    logic [CntWidth-1:0] dec_val;
    logic                irq_q, irq_d;
    logic                tick;
    logic                presc_clear;
    logic                active;
    logic                budget_grew;

    // Prescaler only runs while counting; a reload restarts the budget unit.
    always_comb begin
        presc_clear = (state_q != COUNT) || progress_i;
    end

    budget_prescaler #(
        .Div (PrescalerDiv)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (presc_clear),
        .tick_o  (tick)
    );

    // State, countdown, last-seen budget and irq registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            counter_q <= '0;
            budget_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            budget_q  <= budget_i;
            irq_q     <= irq_d;
        end
    end

    // Next-state selection; progress suppresses an expiring tick.
    always_comb begin
        active  = enable_i && (outstanding_i != '0);
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (active) state_d = COUNT;
            end
            COUNT: begin
                if (!active) begin
                    state_d = IDLE;
                end else if (!progress_i && tick && (counter_q == '0)) begin
                    state_d = TIMEOUT;
                end
            end
            TIMEOUT: begin
                if (clear_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Countdown datapath: load, reload, decrement, and raise on budget growth.
    // Growth is detected against last cycle's budget so a steady budget does
    // not keep pulling the decrementing counter back up.
    always_comb begin
        budget_grew = (budget_i > budget_q);
        dec_val     = (tick && (counter_q != '0)) ? (counter_q - ONE) : counter_q;
        counter_d   = '0;
        irq_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (state_d == COUNT) counter_d = budget_i;
            end
            COUNT: begin
                if (state_d == TIMEOUT) begin
                    irq_d = 1'b1;
                end else if (state_d == COUNT) begin
                    if (progress_i) begin
                        counter_d = budget_i;
                    end else if (budget_grew && (budget_i > dec_val)) begin
                        counter_d = budget_i;
                    end else begin
                        counter_d = dec_val;
                    end
                end
            end
            default: counter_d = '0;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        timeout_o   = (state_q == TIMEOUT);
        irq_o       = irq_q;
        remaining_o = counter_q;
    end

endmodule
